// File: rtl/deser_pkg.sv
// ---------------------------------------------------------------------------
// deser_pkg
// Shared types and constants for the serial-to-parallel deserializer.
//   DATA_W   : parallel word width (16)
//   CNT_W    : bit-counter / frame-length field width ($clog2(DATA_W) = 4)
//   MOD_FULL : frame-length code meaning "full DATA_W-bit frame"
//   MOD_MIN  : smallest legal explicit frame length
//   state_t  : receive FSM states
// ---------------------------------------------------------------------------
package deser_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] MOD_FULL = '0;
  localparam logic [CNT_W-1:0] MOD_MIN  = CNT_W'(3);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Lengths 1 and 2 are reserved; 0 encodes a full-width frame.
  function automatic logic mod_legal(input logic [CNT_W-1:0] mod);
    return (mod == MOD_FULL) || (mod >= MOD_MIN);
  endfunction

  // Bits still expected after the first one has been taken: len - 1.
  function automatic logic [CNT_W-1:0] mod_to_load(input logic [CNT_W-1:0] mod);
    return (mod == MOD_FULL) ? CNT_W'(DATA_W - 1) : mod - CNT_W'(1);
  endfunction

endpackage

// File: rtl/deserializer_if.sv
// ---------------------------------------------------------------------------
// deserializer_if
// Serial input stream and parallel output word of the deserializer.
//   i_data           : serial data bit
//   i_data_val       : i_data qualifier
//   i_data_mod       : frame length, sampled with the first bit of a frame
//   o_deser_data     : assembled, left-aligned word
//   o_deser_data_val : one-cycle completion pulse
//   o_busy           : frame in progress
// Modports: master = stream source / word consumer, slave = deserializer.
// ---------------------------------------------------------------------------
interface deserializer_if;
  import deser_pkg::*;

  logic              i_data;
  logic              i_data_val;
  logic [CNT_W-1:0]  i_data_mod;
  logic [DATA_W-1:0] o_deser_data;
  logic              o_deser_data_val;
  logic              o_busy;

  modport master (
    output i_data, i_data_val, i_data_mod,
    input  o_deser_data, o_deser_data_val, o_busy
  );

  modport slave (
    input  i_data, i_data_val, i_data_mod,
    output o_deser_data, o_deser_data_val, o_busy
  );

endinterface

// File: rtl/deser_bit_counter.sv
// ---------------------------------------------------------------------------
// deser_bit_counter
// Loadable down-counter holding the number of bits still expected.
//   clk, i_srst : clock, synchronous active-high reset
//   i_load      : load i_load_val (has priority over i_dec)
//   i_load_val  : value to load
//   i_dec       : decrement by one (saturates at zero)
//   o_last      : count == 1, the next accepted bit ends the frame
//   o_busy      : count != 0
// ---------------------------------------------------------------------------
module deser_bit_counter
  import deser_pkg::*;
(
  input  logic             clk,
  input  logic             i_srst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last,
  output logic             o_busy
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (i_dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_last = (count_q == CNT_W'(1));
  assign o_busy = (count_q != '0);

endmodule

// File: rtl/deserializer.sv
// ---------------------------------------------------------------------------
// deserializer
// Assembles a qualified MSB-first serial stream into left-aligned DATA_W-bit
// words. The frame length is taken from i_data_mod with the first bit; each
// completed frame is registered to o_deser_data with a one-cycle valid pulse.
//   clk    : clock, all logic on posedge
//   i_srst : synchronous active-high reset, highest priority
//   bus    : deserializer_if.slave (serial in, parallel out, busy)
// ---------------------------------------------------------------------------
module deserializer
  import deser_pkg::*;
(
  input  logic           clk,
  input  logic           i_srst,
  deserializer_if.slave  bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CNT_W-1:0]  pos_q,   pos_d;   // bit index the next RECV bit lands in
  logic              val_q,   val_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_dec;
  logic              cnt_last;
  logic              cnt_busy;

  deser_bit_counter u_bit_counter (
    .clk        (clk),
    .i_srst     (i_srst),
    .i_load     (cnt_load),
    .i_load_val (cnt_load_val),
    .i_dec      (cnt_dec),
    .o_last     (cnt_last),
    .o_busy     (cnt_busy)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned -- that is what keeps this block free of latches.
    state_d      = state_q;
    shift_d      = shift_q;
    pos_d        = pos_q;
    data_d       = data_q;
    val_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = mod_to_load(bus.i_data_mod);

    case (state_q)
      IDLE: begin
        // Illegal lengths fall through: the bit is dropped and we stay idle.
        if (bus.i_data_val && mod_legal(bus.i_data_mod)) begin
          shift_d             = '0;
          shift_d[DATA_W-1]   = bus.i_data;
          pos_d               = CNT_W'(DATA_W - 2);
          cnt_load            = 1'b1;
          state_d             = RECV;
        end
      end

      RECV: begin
        if (bus.i_data_val) begin
          shift_d[pos_q] = bus.i_data;
          pos_d          = pos_q - CNT_W'(1);
          cnt_dec        = cnt_busy;
          if (cnt_last) begin
            // Take the word including the bit written this cycle.
            data_d  = shift_d;
            val_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (i_srst) begin
      // NOTE: the shift word is reset too; it is small, and a clean value
      // keeps X out of the low bits of short frames after power-up.
      state_q <= IDLE;
      shift_q <= '0;
      pos_q   <= '0;
      data_q  <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pos_q   <= pos_d;
      data_q  <= data_d;
      val_q   <= val_d;
    end
  end

  assign bus.o_deser_data     = data_q;
  assign bus.o_deser_data_val = val_q;
  assign bus.o_busy           = (state_q == RECV);

endmodule

// File: tb/tb_deserializer.sv
// ---------------------------------------------------------------------------
// tb_deserializer
// Self-checking bench for deserializer. A queue-based reference model keeps
// the bits of the current frame and forms the expected word when the queue
// reaches the frame length; every cycle the DUT outputs are compared with it.
// ---------------------------------------------------------------------------
module tb_deserializer;
  import deser_pkg::*;

  logic clk = 1'b0;
  logic i_srst;

  deserializer_if bus ();

  deserializer dut (
    .clk    (clk),
    .i_srst (i_srst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state.
  bit          in_frame = 1'b0;
  int          flen     = 0;
  bit          bits[$];
  logic [15:0] exp_data = '0;
  bit          exp_val  = 1'b0;
  bit          exp_busy = 1'b0;

  // Observation bookkeeping, cleared per scenario.
  int          pulses      = 0;
  int          busy_cycles = 0;
  int          rise_cyc    = -1;
  bit          prev_busy   = 1'b0;
  int          pulse_cyc[$];
  logic [15:0] pulse_word[$];

  task automatic clear_obs();
    pulses      = 0;
    busy_cycles = 0;
    rise_cyc    = -1;
    pulse_cyc.delete();
    pulse_word.delete();
  endtask

  // Drive one cycle, advance the model by the same edge, then compare.
  task automatic step(input bit rst, input bit val, input bit d, input logic [3:0] mod);
    logic [15:0] word;
    i_srst         = rst;
    bus.i_data_val = val;
    bus.i_data     = d;
    bus.i_data_mod = mod;
    @(posedge clk);
    cyc++;
    exp_val = 1'b0;
    if (rst) begin
      in_frame = 1'b0;
      bits.delete();
      exp_data = '0;
    end else if (val) begin
      if (!in_frame) begin
        if (mod != 4'd1 && mod != 4'd2) begin
          in_frame = 1'b1;
          flen     = (mod == 4'd0) ? 16 : int'(mod);
          bits.delete();
          bits.push_back(d);
        end
      end else begin
        bits.push_back(d);
      end
      if (in_frame && bits.size() == flen) begin
        word = '0;
        for (int i = 0; i < flen; i++) word[15 - i] = bits[i];
        exp_data = word;
        exp_val  = 1'b1;
        in_frame = 1'b0;
      end
    end
    exp_busy = in_frame;
    #1;
    total++;
    if (bus.o_deser_data_val !== exp_val) begin
      bad++;
      $display("FAIL valid cyc=%0d got=%b want=%b", cyc, bus.o_deser_data_val, exp_val);
    end
    total++;
    if (bus.o_busy !== exp_busy) begin
      bad++;
      $display("FAIL busy cyc=%0d got=%b want=%b", cyc, bus.o_busy, exp_busy);
    end
    total++;
    if (bus.o_deser_data !== exp_data) begin
      bad++;
      $display("FAIL data cyc=%0d got=%h want=%h", cyc, bus.o_deser_data, exp_data);
    end
    if (bus.o_deser_data_val === 1'b1) begin
      pulses++;
      pulse_cyc.push_back(cyc);
      pulse_word.push_back(bus.o_deser_data);
    end
    if (bus.o_busy === 1'b1) begin
      busy_cycles++;
      if (!prev_busy && rise_cyc < 0) rise_cyc = cyc;
    end
    prev_busy = (bus.o_busy === 1'b1);
  endtask

  // Send the first n bits of word MSB first; mod is shown with the first bit
  // and replaced by random junk afterwards (it must be ignored in RECV).
  task automatic send_bits(input logic [3:0] mod, input logic [15:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, word[15 - i], (i == 0) ? mod : 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    total++;
    if (bus.o_deser_data !== 16'h0 || bus.o_deser_data_val !== 1'b0 || bus.o_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got=%h/%b/%b want=0000/0/0",
               bus.o_deser_data, bus.o_deser_data_val, bus.o_busy);
    end
  endtask

  task automatic test_full_frame();
    clear_obs();
    send_bits(4'd0, 16'hA5C3, 16);
    idle(2);
    total++;
    if (pulses !== 1 || pulse_word.size() == 0 || pulse_word[0] !== 16'hA5C3) begin
      bad++;
      $display("FAIL full_frame pulses=%0d want=1 word=%h want=a5c3",
               pulses, (pulse_word.size() > 0) ? pulse_word[0] : 16'hxxxx);
    end
    // Busy rises after bit 1; the frame window from busy rise to the pulse
    // inclusive covers the 16 bit times.
    total++;
    if (pulse_cyc.size() == 0 || rise_cyc < 0 || pulse_cyc[0] - rise_cyc + 1 != 16 || busy_cycles != 15) begin
      bad++;
      $display("FAIL full_busy window=%0d want=16 busy=%0d want=15",
               (pulse_cyc.size() > 0) ? pulse_cyc[0] - rise_cyc + 1 : -1, busy_cycles);
    end
  endtask

  task automatic test_short_frame();
    clear_obs();
    send_bits(4'd3, 16'hA000, 3);
    idle(1);
    total++;
    if (pulses !== 1 || pulse_word.size() == 0 || pulse_word[0] !== 16'hA000) begin
      bad++;
      $display("FAIL short3 pulses=%0d want=1 word=%h want=a000",
               pulses, (pulse_word.size() > 0) ? pulse_word[0] : 16'hxxxx);
    end
    clear_obs();
    send_bits(4'd15, 16'hFFFE, 15);
    idle(1);
    total++;
    if (pulses !== 1 || pulse_word.size() == 0 || pulse_word[0] !== 16'hFFFE) begin
      bad++;
      $display("FAIL short15 pulses=%0d want=1 word=%h want=fffe",
               pulses, (pulse_word.size() > 0) ? pulse_word[0] : 16'hxxxx);
    end
  endtask

  task automatic test_illegal();
    clear_obs();
    step(1'b0, 1'b1, 1'b1, 4'd1);
    idle(1);
    step(1'b0, 1'b1, 1'b1, 4'd2);
    idle(2);
    total++;
    if (pulses != 0 || busy_cycles != 0) begin
      bad++;
      $display("FAIL illegal_mod pulses=%0d busy=%0d want=0/0", pulses, busy_cycles);
    end
    clear_obs();
    send_bits(4'd4, 16'hD000, 4);
    idle(1);
    total++;
    if (pulses !== 1 || pulse_word.size() == 0 || pulse_word[0] !== 16'hD000) begin
      bad++;
      $display("FAIL after_illegal pulses=%0d want=1 word=%h want=d000",
               pulses, (pulse_word.size() > 0) ? pulse_word[0] : 16'hxxxx);
    end
  endtask

  task automatic test_gaps();
    clear_obs();
    step(1'b0, 1'b1, 1'b1, 4'd5);
    step(1'b0, 1'b1, 1'b0, 4'd7);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b1, 4'd1);
    step(1'b0, 1'b1, 1'b1, 4'd2);
    idle(1);
    total++;
    if (pulses !== 1 || pulse_word.size() == 0 || pulse_word[0] !== 16'h9800) begin
      bad++;
      $display("FAIL gaps pulses=%0d want=1 word=%h want=9800",
               pulses, (pulse_word.size() > 0) ? pulse_word[0] : 16'hxxxx);
    end
    total++;
    if (busy_cycles != 7) begin
      bad++;
      $display("FAIL gap_busy got=%0d want=7", busy_cycles);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_bits(4'd3, 16'hE000, 3);
    send_bits(4'd3, 16'h4000, 3);
    idle(2);
    total++;
    if (pulses != 2) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=2", pulses);
    end else begin
      total++;
      if (pulse_word[0] !== 16'hE000 || pulse_word[1] !== 16'h4000 || pulse_cyc[1] - pulse_cyc[0] != 3) begin
        bad++;
        $display("FAIL b2b_words got=%h,%h gap=%0d want=e000,4000 gap=3",
                 pulse_word[0], pulse_word[1], pulse_cyc[1] - pulse_cyc[0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_obs();
    send_bits(4'd0, 16'h1234, 8);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    total++;
    if (bus.o_busy !== 1'b0 || bus.o_deser_data !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset busy=%b data=%h want=0/0000", bus.o_busy, bus.o_deser_data);
    end
    idle(10);
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL mid_reset_pulse got=%0d want=0", pulses);
    end
  endtask

  task automatic test_random();
    bit          rst;
    bit          val;
    logic [3:0]  mod;
    clear_obs();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      val = ($urandom_range(0, 9) < 7);
      mod = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 2)) : 4'($urandom_range(0, 15));
      step(rst, val, 1'($urandom), mod);
    end
    idle(2);
    total++;
    if (pulses < 50) begin
      bad++;
      $display("FAIL random_activity pulses=%0d want>=50", pulses);
    end
  endtask

  initial begin
    i_srst         = 1'b1;
    bus.i_data     = 1'b0;
    bus.i_data_val = 1'b0;
    bus.i_data_mod = 4'd0;
    test_reset();
    test_full_frame();
    test_short_frame();
    test_illegal();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
